// File: rtl/x_stream_serializer.sv
// LSB-first serializer that feeds one bit per step_en strobe to a downstream FSM x input.
// Optional build macro: X_STREAM_SERIALIZER_REPEAT_EN adds repeat_mode for looping the held pattern.
//
// state | meaning
// IDLE  | waiting for a load with non-zero len; x held at 0
// SHIFT | bit on x is valid; each step_en advances one bit
// DONE  | one-cycle completion pulse; a load here is accepted directly
module x_stream_serializer #(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             step_en,
`ifdef X_STREAM_SERIALIZER_REPEAT_EN
    input  logic             repeat_mode,
`endif
    output logic             x,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] bits_left
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] WIDTH_CNT = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_CNT   = LEN_W'(1);

    state_t           state;
    logic [WIDTH-1:0] shReg;
    logic [WIDTH-1:0] shNext;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] lenClamped;
    logic             xReg;
    logic             loadOk;

    assign lenClamped = (len > WIDTH_CNT) ? WIDTH_CNT : len;
    // SHIFT never accepts a load, even when it coincides with a step.
    assign loadOk     = load && (len != '0) && (state != SHIFT);
    assign shNext     = shReg >> 1;

`ifdef X_STREAM_SERIALIZER_REPEAT_EN
    logic [WIDTH-1:0] holdPat;
    logic [LEN_W-1:0] holdLen;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            holdPat <= '0;
            holdLen <= '0;
        end else if (loadOk) begin
            holdPat <= pattern;
            holdLen <= lenClamped;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            shReg <= '0;
            cnt   <= '0;
            xReg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (loadOk) begin
                        shReg <= pattern;
                        xReg  <= pattern[0];
                        cnt   <= lenClamped;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (step_en) begin
                        if (cnt > ONE_CNT) begin
                            shReg <= shNext;
                            xReg  <= shNext[0];
                            cnt   <= cnt - ONE_CNT;
                        end
`ifdef X_STREAM_SERIALIZER_REPEAT_EN
                        else if (repeat_mode) begin
                            shReg <= holdPat;
                            xReg  <= holdPat[0];
                            cnt   <= holdLen;
                        end
`endif
                        else begin
                            xReg  <= 1'b0;
                            cnt   <= '0;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (loadOk) begin
                        shReg <= pattern;
                        xReg  <= pattern[0];
                        cnt   <= lenClamped;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    xReg  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign x         = xReg;
    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign bits_left = cnt;

endmodule

// File: tb/tb_x_stream_serializer.sv
// Directed bench for x_stream_serializer: expected bits queued at load, checked and popped per step.
module tb_x_stream_serializer;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] pattern;
    logic [3:0] len;
    logic       step_en;
    logic       repeatMode;
    logic       x;
    logic       busy;
    logic       done;
    logic [3:0] bits_left;

    int passCnt  = 0;
    int totalCnt = 0;
    int failCnt  = 0;

    bit expQ[$];
    bit holdQ[$];
    bit doneExp;

    x_stream_serializer #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .pattern    (pattern),
        .len        (len),
        .step_en    (step_en),
`ifdef X_STREAM_SERIALIZER_REPEAT_EN
        .repeat_mode(repeatMode),
`endif
        .x          (x),
        .busy       (busy),
        .done       (done),
        .bits_left  (bits_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check current outputs against the model, drive inputs, advance, update the model.
    task automatic cycle(input bit ld, input logic [7:0] pat, input logic [3:0] ln, input bit s);
        bit busyM;
        int n;
        busyM = (expQ.size() != 0);
        chk("busy", busy, busyM);
        chk("done", done, doneExp);
        if (busyM) begin
            chk("x", x, expQ[0]);
            chk("bits_left", bits_left, expQ.size());
        end else begin
            chk("x_quiet", x, 0);
            chk("bits_left_quiet", bits_left, 0);
        end
        load    = ld;
        pattern = pat;
        len     = ln;
        step_en = s;
        @(posedge clk);
        #1;
        load    = 1'b0;
        step_en = 1'b0;
        if (!busyM && ld && ln != 0) begin
            n = (ln > 8) ? 8 : int'(ln);
            expQ.delete();
            for (int i = 0; i < n; i++) expQ.push_back(pat[i]);
            holdQ   = expQ;
            doneExp = 1'b0;
        end else if (busyM && s) begin
            void'(expQ.pop_front());
            if (expQ.size() == 0) begin
                if (repeatMode) begin
                    expQ    = holdQ;
                    doneExp = 1'b0;
                end else begin
                    doneExp = 1'b1;
                end
            end
        end else begin
            doneExp = 1'b0;
        end
    endtask

    initial begin
        reset      = 1'b0;
        load       = 1'b0;
        pattern    = '0;
        len        = '0;
        step_en    = 1'b0;
        repeatMode = 1'b0;
        doneExp    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_x", x, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bits_left", bits_left, 0);
        reset = 1'b1;

        // Full-width pattern, step every cycle
        cycle(1'b1, 8'b0110_1101, 4'd8, 1'b0);
        repeat (8) cycle(1'b0, 8'h00, 4'd0, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 4'd0, 1'b0);

        // Short stream with gapped steps
        cycle(1'b1, 8'hFF, 4'd3, 1'b0);
        cycle(1'b0, 8'h00, 4'd0, 1'b1);
        cycle(1'b0, 8'h00, 4'd0, 1'b0);
        cycle(1'b0, 8'h00, 4'd0, 1'b1);
        cycle(1'b0, 8'h00, 4'd0, 1'b0);
        cycle(1'b0, 8'h00, 4'd0, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 4'd0, 1'b0);

        // len=0 ignored, len=12 clamped to 8
        cycle(1'b1, 8'h55, 4'd0, 1'b0);
        cycle(1'b0, 8'h00, 4'd0, 1'b0);
        cycle(1'b1, 8'hC3, 4'd12, 1'b0);
        repeat (8) cycle(1'b0, 8'h00, 4'd0, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 4'd0, 1'b0);

        // Load mid-SHIFT ignored; load in DONE accepted back-to-back
        cycle(1'b1, 8'hAA, 4'd4, 1'b0);
        cycle(1'b0, 8'h00, 4'd0, 1'b1);
        cycle(1'b1, 8'h00, 4'd2, 1'b1);
        cycle(1'b0, 8'h00, 4'd0, 1'b1);
        cycle(1'b0, 8'h00, 4'd0, 1'b1);
        cycle(1'b1, 8'h0B, 4'd2, 1'b0);
        repeat (2) cycle(1'b0, 8'h00, 4'd0, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 4'd0, 1'b0);

        // Reset after 3 of 8 steps aborts with no done
        cycle(1'b1, 8'hB4, 4'd8, 1'b0);
        repeat (3) cycle(1'b0, 8'h00, 4'd0, 1'b1);
        reset = 1'b0;
        #1;
        chk("abort_x", x, 0);
        chk("abort_busy", busy, 0);
        chk("abort_bits_left", bits_left, 0);
        chk("abort_done", done, 0);
        expQ.delete();
        doneExp = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_done_later", done, 0);
        reset = 1'b1;
        cycle(1'b1, 8'h81, 4'd2, 1'b0);
        repeat (2) cycle(1'b0, 8'h00, 4'd0, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 4'd0, 1'b0);

`ifdef X_STREAM_SERIALIZER_REPEAT_EN
        // Repeat mode loops the held pattern until it drops
        repeatMode = 1'b1;
        cycle(1'b1, 8'h05, 4'd3, 1'b0);
        repeat (4) cycle(1'b0, 8'h00, 4'd0, 1'b1);
        repeatMode = 1'b0;
        repeat (2) cycle(1'b0, 8'h00, 4'd0, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 4'd0, 1'b0);
`endif

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
